// File: rtl/cpi_pkg.sv
// Shared CPI global-channel definitions.
// Link state encoding and epoch ID width.
package cpi_pkg;

    localparam int CPI_EPOCH_ID_WIDTH = 10;

    typedef enum logic [2:0] {
        DISCONNECTED  = 3'd0,
        CONNECTING    = 3'd1,
        CONNECTED     = 3'd2,
        DISCONNECTING = 3'd3,
        ERROR         = 3'd4
    } cpi_link_state_e;

endpackage

// File: rtl/cpi_epoch_tracker.sv
// In-order epoch ID allocator with pending count
// and last committed/rejected epoch registers.
module cpi_epoch_tracker
    import cpi_pkg::*;
#(
    parameter int EPOCH_ID_WIDTH = CPI_EPOCH_ID_WIDTH,
    parameter int MAX_PENDING    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      adv,
    input  logic                      resolve,
    input  logic                      ok,
    output logic [EPOCH_ID_WIDTH-1:0] epoch_id,
    output logic [EPOCH_ID_WIDTH-1:0] epoch_commit,
    output logic [EPOCH_ID_WIDTH-1:0] epoch_reject,
    output logic [EPOCH_ID_WIDTH-1:0] pending,
    output logic                      full
);

    localparam logic [EPOCH_ID_WIDTH-1:0] MAXP = EPOCH_ID_WIDTH'(MAX_PENDING);

    logic                      acc_adv;
    logic                      acc_res;
    logic [EPOCH_ID_WIDTH-1:0] oldest;
    logic [EPOCH_ID_WIDTH-1:0] pending_nxt;

    // Full uses the registered count, so an adv while full is
    // dropped even when a resolve frees a slot in the same cycle.
    assign acc_adv = en && adv && (pending != MAXP);
    assign acc_res = en && resolve && (pending != '0);
    assign oldest  = epoch_id - pending;

    always_comb begin
        pending_nxt = pending;
        if (acc_adv && !acc_res)
            pending_nxt = pending + 1'b1;
        else if (acc_res && !acc_adv)
            pending_nxt = pending - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epoch_id     <= '0;
            epoch_commit <= '1;
            epoch_reject <= '1;
            pending      <= '0;
            full         <= 1'b0;
        end else begin
            if (acc_adv)
                epoch_id <= epoch_id + 1'b1;
            if (acc_res && ok)
                epoch_commit <= oldest;
            if (acc_res && !ok)
                epoch_reject <= oldest;
            pending <= pending_nxt;
            full    <= (pending_nxt == MAXP);
        end
    end

endmodule

// File: rtl/cpi_agent_link_ctrl.sv
// Agent-side CPI global channel link controller.
// Optional connect/disconnect timeout: define CPI_LINK_TIMEOUT_EN.
module cpi_agent_link_ctrl
    import cpi_pkg::*;
#(
    parameter int EPOCH_ID_WIDTH = CPI_EPOCH_ID_WIDTH,
    parameter int MAX_PENDING    = 4,
    parameter int CONN_TIMEOUT   = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      connect_req_i,
    input  logic                      disconnect_req_i,
    input  logic                      epoch_adv_i,
    input  logic                      epoch_resolve_i,
    input  logic                      epoch_ok_i,
    input  logic                      fatal_i,
    input  logic                      viral_i,
    input  logic                      rxcon_ack_i,
    input  logic                      rxdiscon_nack_i,
    input  logic                      rx_empty_i,
    output logic                      txcon_req_o,
    output logic [EPOCH_ID_WIDTH-1:0] epoch_id_o,
    output logic [EPOCH_ID_WIDTH-1:0] epoch_commit_o,
    output logic [EPOCH_ID_WIDTH-1:0] epoch_reject_o,
    output logic                      fatal_o,
    output logic                      viral_o,
    output logic                      connected_o,
    output logic                      epoch_full_o,
    output logic [2:0]                state_o
);

    cpi_link_state_e           state;
    cpi_link_state_e           state_nxt;
    logic [EPOCH_ID_WIDTH-1:0] pending;

`ifdef CPI_LINK_TIMEOUT_EN
    localparam int TW = $clog2(CONN_TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          in_hs;
    logic          tmo_hit;

    assign in_hs   = (state == CONNECTING) || (state == DISCONNECTING);
    assign tmo_hit = in_hs && (tmo_cnt == TW'(CONN_TIMEOUT - 1));
`endif

    always_comb begin
        state_nxt = state;
        if (fatal_i) begin
            state_nxt = ERROR;
        end else begin
            unique case (state)
                DISCONNECTED:
                    if (connect_req_i) state_nxt = CONNECTING;
                CONNECTING:
                    if (rxcon_ack_i) state_nxt = CONNECTED;
                CONNECTED:
                    if (disconnect_req_i && pending == '0)
                        state_nxt = DISCONNECTING;
                DISCONNECTING:
                    if (rxdiscon_nack_i)
                        state_nxt = CONNECTED;
                    else if (!rxcon_ack_i && rx_empty_i)
                        state_nxt = DISCONNECTED;
                ERROR: ;
                default: state_nxt = ERROR;
            endcase
`ifdef CPI_LINK_TIMEOUT_EN
            // A real fabric response in the last cycle still wins.
            if (tmo_hit && state_nxt == state)
                state_nxt = ERROR;
`endif
        end
    end

`ifdef CPI_LINK_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (!in_hs || state_nxt != state)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DISCONNECTED;
            txcon_req_o <= 1'b0;
            connected_o <= 1'b0;
            fatal_o     <= 1'b0;
            viral_o     <= 1'b0;
        end else begin
            state       <= state_nxt;
            txcon_req_o <= (state_nxt == CONNECTING) ||
                           (state_nxt == CONNECTED);
            connected_o <= (state_nxt == CONNECTED);
            fatal_o     <= (state_nxt == ERROR);
            viral_o     <= viral_o | viral_i;
        end
    end

    assign state_o = state;

    cpi_epoch_tracker #(
        .EPOCH_ID_WIDTH (EPOCH_ID_WIDTH),
        .MAX_PENDING    (MAX_PENDING)
    ) u_epoch (
        .clk          (clk),
        .rst          (rst),
        .en           (state == CONNECTED),
        .adv          (epoch_adv_i),
        .resolve      (epoch_resolve_i),
        .ok           (epoch_ok_i),
        .epoch_id     (epoch_id_o),
        .epoch_commit (epoch_commit_o),
        .epoch_reject (epoch_reject_o),
        .pending      (pending),
        .full         (epoch_full_o)
    );

endmodule

// File: tb/tb_cpi_agent_link_ctrl.sv
// Bench for cpi_agent_link_ctrl: directed scenarios plus
// random traffic against a queue-based link/epoch model.
module tb_cpi_agent_link_ctrl;

    localparam int W    = 10;
    localparam int MAXP = 4;
    localparam int TMO  = 16;
    localparam int MOD  = 1 << W;

    logic         clk;
    logic         rst;
    logic         connect_req_i;
    logic         disconnect_req_i;
    logic         epoch_adv_i;
    logic         epoch_resolve_i;
    logic         epoch_ok_i;
    logic         fatal_i;
    logic         viral_i;
    logic         rxcon_ack_i;
    logic         rxdiscon_nack_i;
    logic         rx_empty_i;
    logic         txcon_req_o;
    logic [W-1:0] epoch_id_o;
    logic [W-1:0] epoch_commit_o;
    logic [W-1:0] epoch_reject_o;
    logic         fatal_o;
    logic         viral_o;
    logic         connected_o;
    logic         epoch_full_o;
    logic [2:0]   state_o;

    int n_chk;
    int n_fail;

    int m_state;
    int m_id;
    int m_commit;
    int m_reject;
    int m_viral;
    int m_tin;
    int q[$];

    cpi_agent_link_ctrl #(
        .EPOCH_ID_WIDTH (W),
        .MAX_PENDING    (MAXP),
        .CONN_TIMEOUT   (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .connect_req_i    (connect_req_i),
        .disconnect_req_i (disconnect_req_i),
        .epoch_adv_i      (epoch_adv_i),
        .epoch_resolve_i  (epoch_resolve_i),
        .epoch_ok_i       (epoch_ok_i),
        .fatal_i          (fatal_i),
        .viral_i          (viral_i),
        .rxcon_ack_i      (rxcon_ack_i),
        .rxdiscon_nack_i  (rxdiscon_nack_i),
        .rx_empty_i       (rx_empty_i),
        .txcon_req_o      (txcon_req_o),
        .epoch_id_o       (epoch_id_o),
        .epoch_commit_o   (epoch_commit_o),
        .epoch_reject_o   (epoch_reject_o),
        .fatal_o          (fatal_o),
        .viral_o          (viral_o),
        .connected_o      (connected_o),
        .epoch_full_o     (epoch_full_o),
        .state_o          (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("state", int'(state_o), m_state);
        chk("txcon", int'(txcon_req_o),
            int'(m_state == 1 || m_state == 2));
        chk("connected", int'(connected_o), int'(m_state == 2));
        chk("fatal", int'(fatal_o), int'(m_state == 4));
        chk("viral", int'(viral_o), m_viral);
        chk("epoch_id", int'(epoch_id_o), m_id);
        chk("commit", int'(epoch_commit_o), m_commit);
        chk("reject", int'(epoch_reject_o), m_reject);
        chk("full", int'(epoch_full_o), int'(q.size() == MAXP));
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_id     = 0;
        m_commit = MOD - 1;
        m_reject = MOD - 1;
        m_viral  = 0;
        m_tin    = 0;
        q.delete();
    endtask

    task automatic model_step();
        int  ns;
        int  pend0;
        int  old;
        bit  en;
        pend0 = q.size();
        en    = (m_state == 2);
        if (en && epoch_resolve_i && pend0 > 0) begin
            old = q.pop_front();
            if (epoch_ok_i) m_commit = old;
            else            m_reject = old;
        end
        if (en && epoch_adv_i && pend0 < MAXP) begin
            q.push_back(m_id);
            m_id = (m_id + 1) % MOD;
        end
        ns = m_state;
        if (fatal_i) ns = 4;
        else begin
            case (m_state)
                0: if (connect_req_i) ns = 1;
                1: if (rxcon_ack_i) ns = 2;
                2: if (disconnect_req_i && pend0 == 0) ns = 3;
                3: if (rxdiscon_nack_i) ns = 2;
                   else if (!rxcon_ack_i && rx_empty_i) ns = 0;
                default: ns = m_state;
            endcase
`ifdef CPI_LINK_TIMEOUT_EN
            if (ns == m_state && (m_state == 1 || m_state == 3)
                && m_tin + 1 >= TMO)
                ns = 4;
`endif
        end
        if (ns == m_state && (ns == 1 || ns == 3)) m_tin++;
        else m_tin = 0;
        m_state = ns;
        if (viral_i) m_viral = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        connect_req_i    = 0;
        disconnect_req_i = 0;
        epoch_adv_i      = 0;
        epoch_resolve_i  = 0;
        epoch_ok_i       = 0;
        fatal_i          = 0;
        viral_i          = 0;
        rxcon_ack_i      = 0;
        rxdiscon_nack_i  = 0;
        rx_empty_i       = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_txcon_async", int'(txcon_req_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clear_inputs();
        rst = 1'b1;
        #12;
        do_reset();
        chk("rst_commit", int'(epoch_commit_o), 1023);
        chk("rst_state", int'(state_o), 0);

        // connect with ack three cycles after the request
        connect_req_i = 1;
        tick();
        chk("conn_txcon", int'(txcon_req_o), 1);
        connect_req_i = 0;
        tick();
        tick();
        rxcon_ack_i = 1;
        tick();
        chk("conn_connected", int'(connected_o), 1);
        chk("conn_state", int'(state_o), 2);

        // fill epochs; fifth adv dropped
        epoch_adv_i = 1;
        repeat (5) tick();
        epoch_adv_i = 0;
        chk("ep_id4", int'(epoch_id_o), 4);
        chk("ep_full", int'(epoch_full_o), 1);
        epoch_resolve_i = 1;
        epoch_ok_i = 1;
        tick();
        epoch_ok_i = 0;
        tick();
        chk("ep_commit0", int'(epoch_commit_o), 0);
        chk("ep_reject1", int'(epoch_reject_o), 1);
        chk("ep_notfull", int'(epoch_full_o), 0);
        epoch_ok_i = 1;
        tick();
        tick();
        tick();
        epoch_resolve_i = 0;

        // disconnect with nack, then clean drop
        disconnect_req_i = 1;
        tick();
        chk("disc_state", int'(state_o), 3);
        disconnect_req_i = 0;
        rxdiscon_nack_i = 1;
        tick();
        rxdiscon_nack_i = 0;
        chk("nack_state", int'(state_o), 2);
        chk("nack_txcon", int'(txcon_req_o), 1);
        disconnect_req_i = 1;
        tick();
        disconnect_req_i = 0;
        rxcon_ack_i = 0;
        rx_empty_i = 1;
        tick();
        chk("drop_state", int'(state_o), 0);

        viral_i = 1;
        tick();
        viral_i = 0;
        tick();
        chk("viral_sticky", int'(viral_o), 1);
        chk("viral_state", int'(state_o), 0);

        // reset in the middle of a handshake
        connect_req_i = 1;
        tick();
        #2;
        do_reset();
        connect_req_i = 0;

        // wrap the epoch ID
        connect_req_i = 1;
        tick();
        rxcon_ack_i = 1;
        connect_req_i = 0;
        tick();
        for (int i = 0; i < MOD - 1; i++) begin
            epoch_adv_i = 1;
            tick();
            epoch_adv_i = 0;
            epoch_resolve_i = 1;
            epoch_ok_i = $urandom_range(0, 1) == 1;
            tick();
            epoch_resolve_i = 0;
        end
        chk("wrap_pre", int'(epoch_id_o), 1023);
        epoch_adv_i = 1;
        tick();
        epoch_adv_i = 0;
        chk("wrap_id0", int'(epoch_id_o), 0);
        epoch_resolve_i = 1;
        epoch_ok_i = 1;
        tick();
        epoch_resolve_i = 0;
        chk("wrap_commit", int'(epoch_commit_o), 1023);

        // fatal is sticky and dominates
        fatal_i = 1;
        tick();
        fatal_i = 0;
        chk("fatal_state", int'(state_o), 4);
        chk("fatal_txcon", int'(txcon_req_o), 0);
        connect_req_i = 1;
        epoch_adv_i = 1;
        repeat (3) tick();
        clear_inputs();
        chk("fatal_sticky", int'(fatal_o), 1);

        // no ack while connecting
        do_reset();
        connect_req_i = 1;
        repeat (1000) tick();
        connect_req_i = 0;
`ifdef CPI_LINK_TIMEOUT_EN
        chk("tmo_state", int'(state_o), 4);
`else
        chk("no_tmo_state", int'(state_o), 1);
`endif

        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            connect_req_i    = $urandom_range(0, 1);
            disconnect_req_i = $urandom_range(0, 9) < 2;
            epoch_adv_i      = $urandom_range(0, 9) < 4;
            epoch_resolve_i  = $urandom_range(0, 9) < 4;
            epoch_ok_i       = $urandom_range(0, 1);
            rxcon_ack_i      = $urandom_range(0, 9) < 6;
            rxdiscon_nack_i  = $urandom_range(0, 9) < 1;
            rx_empty_i       = $urandom_range(0, 9) < 7;
            viral_i          = $urandom_range(0, 999) == 0;
            tick();
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
